// File: rtl/lfsr128_check.sv
// lfsr128_check: PRBS checker for the x^128+x^126+x^101+x^99 XNOR LFSR.
// Define LFSR128_CHECK_RESYNC_EN to re-seed after ERR_LIMIT window errors.
module lfsr128_check #(
  parameter int ERR_LIMIT = 8,
  parameter int WINDOW    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        locked,
  output logic        err_pulse,
  output logic [31:0] err_count,
  output logic [31:0] bit_count
);

  typedef enum logic {
    SEED  = 1'b0,
    CHECK = 1'b1
  } state_t;

  state_t       state;
  state_t       state_n;
  logic [127:0] s;
  logic [127:0] s_n;
  logic [127:0] shifted;
  logic [6:0]   seed_cnt;
  logic [6:0]   seed_cnt_n;
  logic [15:0]  win_bits;
  logic [15:0]  win_bits_n;
  logic [15:0]  win_errs;
  logic [15:0]  win_errs_n;
  logic [15:0]  errs_inc;
  logic         locked_n;
  logic         pulse_n;
  logic [31:0]  err_n;
  logic [31:0]  bits_n;
  logic         pred;
  logic         miss;
  logic         limit_hit;
  logic         win_end;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign pred      = ~(s[127] ^ s[125] ^ s[100] ^ s[98]);
  assign miss      = bit_in ^ pred;
  assign shifted   = {s[126:0], bit_in};
  assign errs_inc  = win_errs + {15'd0, miss};
  assign limit_hit = errs_inc >= 16'(ERR_LIMIT);
  assign win_end   = win_bits == 16'(WINDOW - 1);

  always_comb begin
    state_n    = state;
    s_n        = s;
    seed_cnt_n = seed_cnt;
    win_bits_n = win_bits;
    win_errs_n = win_errs;
    locked_n   = locked;
    pulse_n    = 1'b0;
    err_n      = err_count;
    bits_n     = bit_count;
    if (clear) begin
      state_n    = SEED;
      locked_n   = 1'b0;
      seed_cnt_n = '0;
      win_bits_n = '0;
      win_errs_n = '0;
      err_n      = '0;
      bits_n     = '0;
    end else if (bit_valid) begin
      unique case (state)
        SEED: begin
          s_n = shifted;
          if (seed_cnt == 7'd127) begin
            seed_cnt_n = '0;
            // an all-ones load would lock the XNOR predictor forever
            if (!(&shifted)) begin
              state_n    = CHECK;
              locked_n   = 1'b1;
              win_bits_n = '0;
              win_errs_n = '0;
            end
          end else begin
            seed_cnt_n = seed_cnt + 7'd1;
          end
        end
        CHECK: begin
          s_n    = {s[126:0], pred};
          bits_n = sat_inc(bit_count);
          if (miss) begin
            pulse_n = 1'b1;
            err_n   = sat_inc(err_count);
          end
          if (limit_hit || win_end) begin
            win_bits_n = '0;
            win_errs_n = '0;
          end else begin
            win_bits_n = win_bits + 16'd1;
            win_errs_n = errs_inc;
          end
`ifdef LFSR128_CHECK_RESYNC_EN
          if (limit_hit) begin
            state_n    = SEED;
            locked_n   = 1'b0;
            seed_cnt_n = '0;
          end
`endif
        end
        default: state_n = SEED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEED;
      s         <= '0;
      seed_cnt  <= '0;
      win_bits  <= '0;
      win_errs  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      state     <= state_n;
      s         <= s_n;
      seed_cnt  <= seed_cnt_n;
      win_bits  <= win_bits_n;
      win_errs  <= win_errs_n;
      locked    <= locked_n;
      err_pulse <= pulse_n;
      err_count <= err_n;
      bit_count <= bits_n;
    end
  end

endmodule

// File: tb/tb_lfsr128_check.sv
// tb_lfsr128_check: directed PRBS streams with a queued scoreboard.
// Expectations come from the scenario script, one entry per valid bit.
module tb_lfsr128_check;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [31:0] err_count;
  logic [31:0] bit_count;

  int errors = 0;
  int checks = 0;

`ifdef LFSR128_CHECK_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  localparam logic [127:0] SEED0 =
    128'h001bb69a_baf65811_caa417d1_19362a08;

  typedef struct {
    string       tag;
    logic        lk;
    logic        pu;
    logic [31:0] ec;
    logic [31:0] bc;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  logic         pend = 1'b0;
  logic [127:0] gen;

  lfsr128_check #(
    .ERR_LIMIT(8),
    .WINDOW(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .bit_in(bit_in),
    .bit_valid(bit_valid),
    .locked(locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  task automatic next_bit(output logic b);
    b = ~(gen[127] ^ gen[125] ^ gen[100] ^ gen[98]);
    gen = {gen[126:0], b};
  endtask

  task automatic push(input string tag, input logic lk, input logic pu,
                      input int ec, input int bc);
    exp_t e;
    e.tag = tag;
    e.lk  = lk;
    e.pu  = pu;
    e.ec  = 32'(ec);
    e.bc  = 32'(bc);
    q.push_back(e);
  endtask

  task automatic send(input logic b, input logic lk, input logic pu,
                      input int ec, input int bc, input string tag);
    push(tag, lk, pu, ec, bc);
    bit_in    = b;
    bit_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clr(input logic v, input logic b);
    push("clear", 1'b0, 1'b0, 0, 0);
    clear     = 1'b1;
    bit_valid = v;
    bit_in    = b;
    @(posedge clk);
    #1;
    clear     = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_now(input string tag, input logic lk, input logic pu,
                           input int ec, input int bc);
    checks++;
    if (locked !== lk || err_pulse !== pu ||
        err_count !== 32'(ec) || bit_count !== 32'(bc)) begin
      errors++;
      $display("FAIL %s: got locked=%0b pulse=%0b err=%0d bits=%0d, want locked=%0b pulse=%0b err=%0d bits=%0d",
               tag, locked, err_pulse, err_count, bit_count, lk, pu, ec, bc);
    end
  endtask

  // outputs reflect a sampled bit (or clear) one cycle later
  always @(posedge clk) pend = rst_n && (bit_valid || clear);

  always @(negedge clk) begin
    if (pend) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: output with no expected entry, got locked=%0b err=%0d bits=%0d",
                 locked, err_count, bit_count);
      end else begin
        mon_e = q.pop_front();
        if (locked !== mon_e.lk || err_pulse !== mon_e.pu ||
            err_count !== mon_e.ec || bit_count !== mon_e.bc) begin
          errors++;
          $display("FAIL %s: got locked=%0b pulse=%0b err=%0d bits=%0d, want locked=%0b pulse=%0b err=%0d bits=%0d",
                   mon_e.tag, locked, err_pulse, err_count, bit_count,
                   mon_e.lk, mon_e.pu, mon_e.ec, mon_e.bc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b;
    int   ne;
    int   nb;
    gen = SEED0;
    #2 rst_n = 1'b0;
    #1 check_now("reset_state", 1'b0, 1'b0, 0, 0);
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 128; i++) begin
      next_bit(b);
      send(b, i == 127, 1'b0, 0, 0, "seed");
    end
    for (int i = 0; i < 1000; i++) begin
      next_bit(b);
      send(b, 1'b1, 1'b0, 0, i + 1, "clean_run");
    end

    next_bit(b);
    send(~b, 1'b1, 1'b1, 1, 1001, "single_flip");
    idle(1);
    check_now("pulse_one_cycle", 1'b1, 1'b0, 1, 1001);
    for (int i = 0; i < 20; i++) begin
      next_bit(b);
      send(b, 1'b1, 1'b0, 1, 1002 + i, "after_flip");
    end

    next_bit(b);
    clr(1'b1, b);
    for (int i = 0; i < 128; i++) begin
      next_bit(b);
      send(b, i == 127, 1'b0, 0, 0, "reseed");
    end
    ne = 0;
    for (int j = 0; j < 32; j++) begin
      next_bit(b);
      if (j % 4 == 3) begin
        ne++;
        send(~b, !(RESYNC && ne == 8), 1'b1, ne, j + 1, "burst_err");
      end else begin
        send(b, 1'b1, 1'b0, ne, j + 1, "burst_ok");
      end
    end
    nb = 32;
    for (int i = 0; i < 128; i++) begin
      next_bit(b);
      if (RESYNC) begin
        send(b, i == 127, 1'b0, 8, nb, "resync_seed");
      end else begin
        nb++;
        send(b, 1'b1, 1'b0, 8, nb, "stay_locked");
      end
    end
    for (int i = 0; i < 4; i++) begin
      next_bit(b);
      nb++;
      send(b, 1'b1, 1'b0, 8, nb, "post_burst");
    end

    idle(1);
    clr(1'b0, 1'b0);
    for (int i = 0; i < 128; i++) begin
      send(1'b1, 1'b0, 1'b0, 0, 0, "ones_seed");
    end
    for (int i = 0; i < 128; i++) begin
      next_bit(b);
      send(b, i == 127, 1'b0, 0, 0, "after_ones");
    end
    for (int i = 0; i < 8; i++) begin
      next_bit(b);
      send(b, 1'b1, 1'b0, 0, i + 1, "ones_locked");
    end

    idle(1);
    clr(1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      next_bit(b);
      send(b, 1'b0, 1'b0, 0, 0, "pre_reset");
    end
    idle(1);
    rst_n = 1'b0;
    #1 check_now("reset_mid_seed", 1'b0, 1'b0, 0, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 128; i++) begin
      next_bit(b);
      send(b, i == 127, 1'b0, 0, 0, "post_reset");
    end
    for (int i = 0; i < 8; i++) begin
      next_bit(b);
      send(b, 1'b1, 1'b0, 0, i + 1, "post_reset_run");
    end

    idle(2);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
